shift_tx_controller: RTL

Sequencer and two-port arbiter for the parallel-load, MSB-first shift register in the serial output path. Two requesters each present a DATA_WIDTH-bit word. The block grants one requester round-robin, loads its word into the shift register, and holds the shift enable for exactly DATA_WIDTH cycles. It then acknowledges the granted requester. It owns every control input of the shift register (load, enable, clear) and provides a frame strobe that qualifies the serial bit.

---
 rtl/shift_tx_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_tx_controller.sv
// Round-robin two-port sequencer for a parallel-load, MSB-first shift register.
// Grants one requester, loads its word, shifts DATA_WIDTH bits, then acknowledges.
module shift_tx_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] sr_data_in,
    output logic                  sr_wr_enable,
    output logic                  sr_enable,
    output logic                  sr_reset,
    output logic                  frame,
    output logic [CNT_WIDTH-1:0]  bit_cnt,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic                 pick_s;

    // Arbitration choice: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        pick_s = 1'b0;
        if (req0 && req1) begin
            pick_s = ~last_grant_q;
        end else begin
            pick_s = req1;
        end
    end

    // Next-state, grant and bit-counter update.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        bit_cnt_d    = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    state_d      = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Counter lands on DATA_WIDTH as we enter DONE and is held there.
                bit_cnt_d = bit_cnt_q + CNT_ONE;
                if (bit_cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            bit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    // Output decode from registered state only; req never reaches an output.
    always_comb begin
        sr_wr_enable = (state_q == ST_LOAD);
        sr_enable    = (state_q == ST_SHIFT);
        frame        = (state_q == ST_SHIFT);
        busy         = (state_q != ST_IDLE);
        ack0         = (state_q == ST_DONE) && !grant_q;
        ack1         = (state_q == ST_DONE) && grant_q;
        bit_cnt      = bit_cnt_q;
        if (state_q == ST_LOAD) begin
            sr_data_in = grant_q ? data1 : data0;
        end else begin
            sr_data_in = '0;
        end
    end

    // The shift register clears on the same edge as this controller.
    assign sr_reset = reset;

endmodule
